// File: rtl/irig_b_encoder.sv
// IRIG-B DC-level (pulse-width-coded) timecode encoder.
// 100 symbols per frame; frame time is loaded through a shadow register or self-advanced by 1 s per frame.
module irig_b_encoder #(
  parameter int unsigned SYM_CYC = 500_000,
  parameter int unsigned W0      = 100_000,
  parameter int unsigned W1      = 250_000,
  parameter int unsigned WP      = 400_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       time_valid,
  input  logic [3:0] sec_u_in,
  input  logic [2:0] sec_t_in,
  input  logic [3:0] min_u_in,
  input  logic [2:0] min_t_in,
  input  logic [3:0] hour_u_in,
  input  logic [1:0] hour_t_in,
  input  logic [3:0] day_u_in,
  input  logic [3:0] day_t_in,
  input  logic [1:0] day_h_in,
  input  logic [3:0] year_u_in,
  input  logic [3:0] year_t_in,
  output logic       bcode_out,
  output logic       frame_start,
  output logic       time_ack
);

  localparam int unsigned CNT_W = (SYM_CYC > 1) ? $clog2(SYM_CYC) : 1;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned VEC_W = 128;

  typedef struct packed {
    logic [3:0] year_t;
    logic [3:0] year_u;
    logic [1:0] day_h;
    logic [3:0] day_t;
    logic [3:0] day_u;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } bcd_time_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   sym_cnt;
  logic [IDX_W-1:0]   bit_idx;
  bcd_time_t          in_time, shadow, frame_t, frame_inc, load_time;
  logic               pending;
  logic               sent;
  logic               running, at_start, take_new, sym_last, p_sym;
  logic [CNT_W-1:0]   sym_w;
  logic [VEC_W-1:0]   data_vec;
  logic               c_sec, c_min, c_hour, c_day;

  assign in_time = {year_t_in, year_u_in, day_h_in, day_t_in, day_u_in,
                    hour_t_in, hour_u_in, min_t_in, min_u_in, sec_t_in, sec_u_in};

  assign running   = (state == ST_RUN) && en;
  assign at_start  = running && (sym_cnt == '0) && (bit_idx == '0);
  assign sym_last  = (sym_cnt == CNT_W'(SYM_CYC - 1));
  assign take_new  = pending | time_valid;
  assign load_time = time_valid ? in_time : shadow;

  // Enable sequencing: one idle edge after en rises, then the frame starts at symbol 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!en)                   state_d = ST_IDLE;
    else if (state == ST_IDLE) state_d = ST_RUN;
  end

  // Symbol width from frame-register bits, laid out by symbol index.
  always_comb begin
    data_vec        = '0;
    data_vec[4:1]   = frame_t.sec_u;
    data_vec[8:6]   = frame_t.sec_t;
    data_vec[13:10] = frame_t.min_u;
    data_vec[17:15] = frame_t.min_t;
    data_vec[23:20] = frame_t.hour_u;
    data_vec[26:25] = frame_t.hour_t;
    data_vec[33:30] = frame_t.day_u;
    data_vec[38:35] = frame_t.day_t;
    data_vec[41:40] = frame_t.day_h;
    data_vec[53:50] = frame_t.year_u;
    data_vec[58:55] = frame_t.year_t;
    p_sym = (bit_idx == 7'd0) ||
            (bit_idx inside {7'd9, 7'd19, 7'd29, 7'd39, 7'd49, 7'd59, 7'd69, 7'd79, 7'd89, 7'd99});
    if (p_sym)                 sym_w = CNT_W'(WP);
    else if (data_vec[bit_idx]) sym_w = CNT_W'(W1);
    else                       sym_w = CNT_W'(W0);
  end

  // +1 s in BCD; ">=" comparisons keep out-of-range digits rolling instead of sticking.
  always_comb begin
    frame_inc = frame_t;
    c_sec = 1'b0; c_min = 1'b0; c_hour = 1'b0; c_day = 1'b0;
    if (frame_t.sec_u >= 4'd9) begin
      frame_inc.sec_u = '0;
      if (frame_t.sec_t >= 3'd5) begin frame_inc.sec_t = '0; c_sec = 1'b1; end
      else frame_inc.sec_t = frame_t.sec_t + 3'd1;
    end else frame_inc.sec_u = frame_t.sec_u + 4'd1;
    if (c_sec) begin
      if (frame_t.min_u >= 4'd9) begin
        frame_inc.min_u = '0;
        if (frame_t.min_t >= 3'd5) begin frame_inc.min_t = '0; c_min = 1'b1; end
        else frame_inc.min_t = frame_t.min_t + 3'd1;
      end else frame_inc.min_u = frame_t.min_u + 4'd1;
    end
    if (c_min) begin
      if (frame_t.hour_t >= 2'd2 && frame_t.hour_u >= 4'd3) begin
        frame_inc.hour_t = '0; frame_inc.hour_u = '0; c_hour = 1'b1;
      end else if (frame_t.hour_u >= 4'd9) begin
        frame_inc.hour_u = '0; frame_inc.hour_t = frame_t.hour_t + 2'd1;
      end else frame_inc.hour_u = frame_t.hour_u + 4'd1;
    end
    if (c_hour) begin
      if (frame_t.day_h >= 2'd3 && frame_t.day_t >= 4'd6 && frame_t.day_u >= 4'd5) begin
        frame_inc.day_h = '0; frame_inc.day_t = '0; frame_inc.day_u = 4'd1; c_day = 1'b1;
      end else if (frame_t.day_u >= 4'd9) begin
        frame_inc.day_u = '0;
        if (frame_t.day_t >= 4'd9) begin
          frame_inc.day_t = '0; frame_inc.day_h = frame_t.day_h + 2'd1;
        end else frame_inc.day_t = frame_t.day_t + 4'd1;
      end else frame_inc.day_u = frame_t.day_u + 4'd1;
    end
    if (c_day) begin
      if (frame_t.year_u >= 4'd9) begin
        frame_inc.year_u = '0;
        frame_inc.year_t = (frame_t.year_t >= 4'd9) ? 4'd0 : frame_t.year_t + 4'd1;
      end else frame_inc.year_u = frame_t.year_u + 4'd1;
    end
  end

  // Time handshake; a frame only advances by 1 s once its predecessor has actually started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      frame_t <= '0;
      pending <= 1'b0;
      sent    <= 1'b0;
    end else begin
      if (time_valid) shadow <= in_time;
      if (at_start) begin
        pending <= 1'b0;
        sent    <= 1'b1;
        if (take_new)  frame_t <= load_time;
        else if (sent) frame_t <= frame_inc;
      end else if (time_valid) begin
        pending <= 1'b1;
      end
    end
  end

  // Symbol counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt     <= '0;
      bit_idx     <= '0;
      bcode_out   <= 1'b0;
      frame_start <= 1'b0;
      time_ack    <= 1'b0;
    end else if (running) begin
      sym_cnt <= sym_last ? '0 : sym_cnt + CNT_W'(1);
      if (sym_last) bit_idx <= (bit_idx == 7'd99) ? '0 : bit_idx + 7'd1;
      bcode_out   <= (sym_cnt < sym_w);
      frame_start <= at_start;
      time_ack    <= at_start && take_new;
    end else begin
      sym_cnt     <= '0;
      bit_idx     <= '0;
      bcode_out   <= 1'b0;
      frame_start <= 1'b0;
      time_ack    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irig_b_encoder.sv
// Directed testbench for irig_b_encoder with short symbol timing.
module tb_irig_b_encoder;

  localparam int SYM = 50;
  localparam int W0  = 10;
  localparam int W1  = 25;
  localparam int WP  = 40;

  typedef struct packed {
    logic [3:0] year_t;
    logic [3:0] year_u;
    logic [1:0] day_h;
    logic [3:0] day_t;
    logic [3:0] day_u;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
  } tb_time_t;

  logic clk, rst_n, en, time_valid;
  logic bcode_out, frame_start, time_ack;
  tb_time_t tin;

  int total = 0;
  int bad   = 0;
  int wid [100];
  int ack_cnt, fs_cnt;
  logic ack_first;

  irig_b_encoder #(.SYM_CYC(SYM), .W0(W0), .W1(W1), .WP(WP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .time_valid(time_valid),
    .sec_u_in(tin.sec_u), .sec_t_in(tin.sec_t),
    .min_u_in(tin.min_u), .min_t_in(tin.min_t),
    .hour_u_in(tin.hour_u), .hour_t_in(tin.hour_t),
    .day_u_in(tin.day_u), .day_t_in(tin.day_t), .day_h_in(tin.day_h),
    .year_u_in(tin.year_u), .year_t_in(tin.year_t),
    .bcode_out(bcode_out), .frame_start(frame_start), .time_ack(time_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic tb_time_t mk(input int h, input int m, input int s, input int d, input int y);
    tb_time_t t;
    t.sec_u  = 4'(s % 10);  t.sec_t  = 3'(s / 10);
    t.min_u  = 4'(m % 10);  t.min_t  = 3'(m / 10);
    t.hour_u = 4'(h % 10);  t.hour_t = 2'(h / 10);
    t.day_u  = 4'(d % 10);  t.day_t  = 4'((d / 10) % 10);  t.day_h = 2'(d / 100);
    t.year_u = 4'(y % 10);  t.year_t = 4'(y / 10);
    return t;
  endfunction

  function automatic int exp_w(input int idx, input tb_time_t t);
    logic b;
    b = 1'b0;
    if (idx == 0 || idx % 10 == 9) return WP;
    if (idx >= 1  && idx <= 4)  b = t.sec_u[idx - 1];
    if (idx >= 6  && idx <= 8)  b = t.sec_t[idx - 6];
    if (idx >= 10 && idx <= 13) b = t.min_u[idx - 10];
    if (idx >= 15 && idx <= 17) b = t.min_t[idx - 15];
    if (idx >= 20 && idx <= 23) b = t.hour_u[idx - 20];
    if (idx >= 25 && idx <= 26) b = t.hour_t[idx - 25];
    if (idx >= 30 && idx <= 33) b = t.day_u[idx - 30];
    if (idx >= 35 && idx <= 38) b = t.day_t[idx - 35];
    if (idx >= 40 && idx <= 41) b = t.day_h[idx - 40];
    if (idx >= 50 && idx <= 53) b = t.year_u[idx - 50];
    if (idx >= 55 && idx <= 58) b = t.year_t[idx - 55];
    return b ? W1 : W0;
  endfunction

  // Waits (bounded) for frame_start, then records high width of each of 100 symbols.
  task automatic capture_frame(input string tag);
    int guard;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 6000) begin
      tick();
      guard++;
    end
    chk({tag, "_fs_seen"}, 32'(frame_start), 1);
    ack_first = time_ack;
    ack_cnt = 0;
    fs_cnt  = 0;
    for (int s = 0; s < 100; s++) begin
      wid[s] = 0;
      for (int c = 0; c < SYM; c++) begin
        if (bcode_out === 1'b1) wid[s]++;
        if (time_ack === 1'b1) ack_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        tick();
      end
    end
  endtask

  task automatic check_frame(input string tag, input tb_time_t t);
    int mism;
    mism = 0;
    for (int s = 0; s < 100; s++)
      if (wid[s] != exp_w(s, t)) mism++;
    chk({tag, "_bad_symbols"}, 32'(mism), 0);
  endtask

  task automatic load(input tb_time_t t);
    tin = t;
    time_valid = 1'b1;
    tick();
    time_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; time_valid = 1'b0; tin = '0;

    // 1: reset values and first frame
    repeat (5) tick();
    chk("rst_bcode", 32'(bcode_out), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_ack", 32'(time_ack), 0);
    rst_n = 1'b1;
    capture_frame("t1");
    chk("t1_w0", 32'(wid[0]), 40);
    chk("t1_fs_count", 32'(fs_cnt), 1);
    chk("t1_ack_count", 32'(ack_cnt), 0);
    check_frame("t1", mk(0, 0, 0, 0, 0));
    en = 1'b0;
    tick();
    chk("t1_en_off_bcode", 32'(bcode_out), 0);

    // 2: load 12:34:56 day 123 year 24, then enable
    load(mk(12, 34, 56, 123, 24));
    tick();
    en = 1'b1;
    capture_frame("t2");
    chk("t2_ack_at_start", 32'(ack_first), 1);
    chk("t2_ack_count", 32'(ack_cnt), 1);
    chk("t2_sym1", 32'(wid[1]), 10);
    chk("t2_sym2", 32'(wid[2]), 25);
    chk("t2_sym3", 32'(wid[3]), 25);
    chk("t2_sym4", 32'(wid[4]), 10);
    chk("t2_sym6", 32'(wid[6]), 25);
    chk("t2_sym7", 32'(wid[7]), 10);
    chk("t2_sym8", 32'(wid[8]), 25);
    chk("t2_sym99", 32'(wid[99]), 40);
    check_frame("t2", mk(12, 34, 56, 123, 24));
    capture_frame("t2b");
    chk("t2b_sym0", 32'(wid[0]), 40);
    chk("t2b_ack_count", 32'(ack_cnt), 0);
    check_frame("t2b", mk(12, 34, 57, 123, 24));

    // 3: free-run rollover from 23:59:59 day 365 year 99
    repeat (7) tick();
    load(mk(23, 59, 59, 365, 99));
    capture_frame("t3a");
    chk("t3a_ack_count", 32'(ack_cnt), 1);
    check_frame("t3a", mk(23, 59, 59, 365, 99));
    capture_frame("t3b");
    chk("t3b_ack_count", 32'(ack_cnt), 0);
    check_frame("t3b", mk(0, 0, 0, 1, 0));

    // 4: time_valid in the transfer cycle
    repeat (SYM * 100 - 1) tick();
    load(mk(10, 20, 30, 200, 30));
    chk("t4_fs_now", 32'(frame_start), 1);
    chk("t4_ack_now", 32'(time_ack), 1);
    capture_frame("t4");
    chk("t4_ack_count", 32'(ack_cnt), 1);
    check_frame("t4", mk(10, 20, 30, 200, 30));

    // 5: drop en during symbol 47, then restart
    repeat (47 * SYM + 2) tick();
    chk("t5_high_before", 32'(bcode_out), 1);
    en = 1'b0;
    tick();
    chk("t5_abort_bcode", 32'(bcode_out), 0);
    chk("t5_abort_fs", 32'(frame_start), 0);
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("t5_k_bcode", 32'(bcode_out), 0);
    tick();
    chk("t5_k1_fs", 32'(frame_start), 1);
    chk("t5_k1_bcode", 32'(bcode_out), 1);
    capture_frame("t5");
    chk("t5_sym0", 32'(wid[0]), 40);
    check_frame("t5", mk(10, 20, 32, 200, 30));

    // 6: asynchronous reset during symbol 20
    repeat (20 * SYM + 3) tick();
    chk("t6_high_before", 32'(bcode_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_bcode", 32'(bcode_out), 0);
    chk("t6_async_fs", 32'(frame_start), 0);
    chk("t6_async_ack", 32'(time_ack), 0);
    tick();
    tick();
    rst_n = 1'b1;
    capture_frame("t6a");
    chk("t6a_ack_count", 32'(ack_cnt), 0);
    check_frame("t6a", mk(0, 0, 0, 0, 0));
    capture_frame("t6b");
    check_frame("t6b", mk(0, 0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
